uart_byte_rx: RTL and testbench

//  Serial receive front end for the UART->Wishbone bridge. Sits between the board serial_rx pin
//  and uart_wb_master, which consumes received bytes as command/address/data stream.

---
 rtl/uart_byte_rx_pkg.sv | 19 +
 rtl/uart_rx_fifo.sv | 46 ++++
 rtl/uart_byte_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_byte_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_byte_rx_pkg.sv
// Shared UART receive definitions: data width and FSM state encodings (also used by the TX side).
package uart_byte_rx_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_t;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; head word is always presented on dout.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_pop;
  logic             do_push;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// UART 8N1 byte receiver with FIFO and sticky error flags; define UART_RX_PARITY_EN for even parity.
//  state        | meaning
//  ST_IDLE      | line idle, waiting for falling edge
//  ST_START     | counting to mid start bit, re-check low
//  ST_DATA      | sampling 8 data bits LSB first
//  ST_PARITY    | sampling even parity bit (UART_RX_PARITY_EN only)
//  ST_STOP      | sampling stop bit
//  ST_WAIT_HIGH | framing error, waiting for line to return high
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       serial_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic       err_clear,
  output logic       frame_error,
  output logic       overrun,
  output logic       parity_error
);

  import uart_byte_rx_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic [1:0]                sync;
  logic                      rx_s;
  rx_state_t                 state;
  logic [CW-1:0]             cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      push_q;
  logic                      frame_evt;
  logic                      par_bad;
  logic                      par_evt;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      overrun_evt;

  assign rx_s = sync[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync <= 2'b11;
    else          sync <= {sync[0], serial_rx};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      push_q    <= 1'b0;
      frame_evt <= 1'b0;
      par_bad   <= 1'b0;
      par_evt   <= 1'b0;
    end else begin
      push_q    <= 1'b0;
      frame_evt <= 1'b0;
      par_evt   <= 1'b0;
      if (cnt != '0) cnt <= cnt - 1'b1;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            cnt     <= HALF_LOAD;
            par_bad <= 1'b0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (cnt == '0) begin
            cnt     <= FULL_LOAD;
            bit_idx <= '0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (cnt == '0) begin
            shift   <= {rx_s, shift[UART_DATA_BITS-1:1]};
            cnt     <= FULL_LOAD;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == '0) begin
            par_bad <= (even_parity(shift) != rx_s);
            par_evt <= (even_parity(shift) != rx_s);
            cnt     <= FULL_LOAD;
            state   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (cnt == '0) begin
            if (rx_s) begin
              push_q <= !par_bad;
              state  <= ST_IDLE;
            end else begin
              frame_evt <= 1'b1;
              state     <= ST_WAIT_HIGH;
            end
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_q),
    .din     (shift),
    .pop     (rx_ready),
    .dout    (rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rx_valid    = !fifo_empty;
  assign overrun_evt = push_q && fifo_full && !rx_ready;

  // New error events take priority over a coincident clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (frame_evt)      frame_error <= 1'b1;
      else if (err_clear) frame_error <= 1'b0;
      if (overrun_evt)    overrun <= 1'b1;
      else if (err_clear) overrun <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_error_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       parity_error_q <= 1'b0;
    else if (par_evt)   parity_error_q <= 1'b1;
    else if (err_clear) parity_error_q <= 1'b0;
  end
  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_byte_rx;

  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       serial_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       err_clear = 1'b0;
  logic       frame_error;
  logic       overrun;
  logic       parity_error;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] rx_q[$];

  uart_byte_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .serial_rx    (serial_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .err_clear    (err_clear),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .parity_error (parity_error)
  );

  always #5 clock = ~clock;

  // Record every byte the consumer accepts (pop happens on the following rising edge).
  always @(negedge clock) begin
    if (reset_n && rx_valid && rx_ready) rx_q.push_back(rx_data);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    serial_rx = b;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`endif
    drive_bit(stop_bit);
    serial_rx = 1'b1;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_frame_error got %b want 0", frame_error); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
    n_checks++; if (parity_error !== 1'b0) begin n_fail++; $display("FAIL reset_parity_error got %b want 0", parity_error); end
    reset_n = 1'b1;
    tick(5);
  endtask

  task automatic test_single_byte();
    rx_q.delete();
    rx_ready = 1'b1;
    send_byte(8'hA5, 1'b1, 1'b0);
    tick(10);
    n_checks++; if (rx_q.size() !== 1) begin n_fail++; $display("FAIL single_count got %0d want 1", rx_q.size()); end
    else begin
      n_checks++; if (rx_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h want a5", rx_q[0]); end
    end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got %b want 0", rx_valid); end
    n_checks++; if ({frame_error, overrun, parity_error} !== 3'b000) begin
      n_fail++; $display("FAIL single_errors got %b want 000", {frame_error, overrun, parity_error});
    end
  endtask

  task automatic test_glitch();
    rx_q.delete();
    rx_ready = 1'b1;
    serial_rx = 1'b0;
    tick(1);
    serial_rx = 1'b1;
    tick(30);
    n_checks++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL glitch_count got %0d want 0", rx_q.size()); end
    n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL glitch_frame got %b want 0", frame_error); end
    // A byte right after the glitch proves the FSM is back in IDLE.
    send_byte(8'h11, 1'b1, 1'b0);
    tick(10);
    n_checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h11) begin
      n_fail++; $display("FAIL glitch_recover got n=%0d d=%h want n=1 d=11", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_frame_error();
    rx_q.delete();
    rx_ready = 1'b1;
    send_byte(8'h3C, 1'b0, 1'b0);
    serial_rx = 1'b0;
    tick(40);
    n_checks++; if (frame_error !== 1'b1) begin n_fail++; $display("FAIL frame_flag got %b want 1", frame_error); end
    n_checks++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL frame_dropped got %0d bytes want 0", rx_q.size()); end
    serial_rx = 1'b1;
    tick(3 * CPB);
    send_byte(8'h11, 1'b1, 1'b0);
    tick(10);
    n_checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h11) begin
      n_fail++; $display("FAIL frame_next_byte got n=%0d d=%h want n=1 d=11", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
    n_checks++; if (frame_error !== 1'b1) begin n_fail++; $display("FAIL frame_sticky got %b want 1", frame_error); end
    pulse_clear();
    n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL frame_clear got %b want 0", frame_error); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp_q[$];
    rx_q.delete();
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1'b0);
    tick(10);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b want 1", overrun); end
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got %b want 1", rx_valid); end
    n_checks++; if (rx_data !== 8'h01) begin n_fail++; $display("FAIL ovr_head got %h want 01", rx_data); end
    rx_ready = 1'b1;
    tick(8);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    n_checks++; if (rx_q.size() !== 4) begin n_fail++; $display("FAIL ovr_count got %0d want 4", rx_q.size()); end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovr_order[%0d] got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_empty got %b want 0", rx_valid); end
    pulse_clear();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", overrun); end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] d;
    d = 8'h77;
    rx_q.delete();
    rx_ready = 1'b0;
    send_byte(8'h99, 1'b1, 1'b0);
    tick(10);
    n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h99) begin
      n_fail++; $display("FAIL rmid_preload got v=%b d=%h want v=1 d=99", rx_valid, rx_data);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    serial_rx = d[4];
    tick(CPB / 2);
    reset_n = 1'b0;
    tick(2);
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", rx_valid); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rmid_data got %h want 00", rx_data); end
    n_checks++; if ({frame_error, overrun, parity_error} !== 3'b000) begin
      n_fail++; $display("FAIL rmid_errors got %b want 000", {frame_error, overrun, parity_error});
    end
    serial_rx = 1'b1;
    reset_n = 1'b1;
    tick(3 * CPB);
    rx_ready = 1'b1;
    send_byte(8'h5A, 1'b1, 1'b0);
    tick(12 * CPB);
    n_checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h5A) begin
      n_fail++; $display("FAIL rmid_next got n=%0d d=%h want n=1 d=5a", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
    n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL rmid_no_frame got %b want 0", frame_error); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    rx_q.delete();
    rx_ready = 1'b1;
    send_byte(8'h07, 1'b1, 1'b0);
    tick(10);
    n_checks++; if (parity_error !== 1'b1) begin n_fail++; $display("FAIL par_flag got %b want 1", parity_error); end
    n_checks++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL par_dropped got %0d want 0", rx_q.size()); end
    n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL par_frame got %b want 0", frame_error); end
    pulse_clear();
    send_byte(8'h07, 1'b1, 1'b1);
    tick(10);
    n_checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h07) begin
      n_fail++; $display("FAIL par_good got n=%0d d=%h want n=1 d=07", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
    n_checks++; if (parity_error !== 1'b0) begin n_fail++; $display("FAIL par_clear got %b want 0", parity_error); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_mid_byte();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
